// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache request interface: services dcache
// word reads/writes and icache reads against a word-addressed RAM with fixed latency.
module cache_mem_responder #(
   parameter int ADDR_BITS   = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 dREN,
   input  logic                 dWEN,
   input  logic [ADDR_BITS-1:0] daddr,
   input  logic [31:0]          dstore,
   output logic                 dwait,
   output logic [31:0]          dload,
   output logic                 load_done,
   output logic                 store_done,
   input  logic                 iREN,
   input  logic [ADDR_BITS-1:0] iaddr,
   output logic                 iwait,
   output logic [31:0]          iload,
   output logic                 busy
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t               state, next_state;
   logic [CNT_W-1:0]     count, next_count;
   logic                 lat_wr, lat_isrc;
   logic [ADDR_BITS-1:0] lat_addr;
   logic [31:0]          lat_data;
   logic [31:0]          mem [DEPTH_WORDS];

   logic                 accept, match, done;
   logic                 req_wr, req_isrc;
   logic [ADDR_BITS-1:0] req_addr;
   logic [IDX_W-1:0]     idx;

   assign idx = lat_addr[IDX_W+1:2];

   // State register plus the request latch captured at IDLE arbitration
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         count    <= '0;
         lat_wr   <= 1'b0;
         lat_isrc <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
      end else begin
         state <= next_state;
         count <= next_count;
         if (accept) begin
            lat_wr   <= req_wr;
            lat_isrc <= req_isrc;
            lat_addr <= req_addr;
            lat_data <= dstore;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem[IDX_W'(i)] <= '0;
         end
      end else if (done && !lat_isrc && lat_wr) begin
         mem[idx] <= lat_data;
      end
   end

   // A dcache write wins over a read; icache is served only when dcache is idle
   always_comb begin
      next_state = state;
      next_count = count;
      accept     = 1'b0;
      match      = 1'b0;
      done       = 1'b0;
      req_wr     = dWEN;
      req_isrc   = !(dREN || dWEN);
      req_addr   = req_isrc ? iaddr : daddr;
      case (state)
         IDLE: begin
            if (dREN || dWEN || iREN) begin
               accept     = 1'b1;
               next_state = ACCESS;
               next_count = '0;
            end
         end
         ACCESS: begin
            if (lat_isrc) begin
               match = iREN && (iaddr == lat_addr);
            end else begin
               match = (dREN || dWEN) && (dWEN == lat_wr) && (daddr == lat_addr);
            end
            if (!match) begin
               next_state = IDLE;
            end else if (count == LAST) begin
               done       = 1'b1;
               next_state = IDLE;
            end else begin
               next_count = count + 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      dwait      = 1'b1;
      iwait      = 1'b1;
      dload      = '0;
      iload      = '0;
      load_done  = 1'b0;
      store_done = 1'b0;
      busy       = (state == ACCESS);
      if (done) begin
         if (lat_isrc) begin
            iwait = 1'b0;
            iload = mem[idx];
         end else begin
            dwait = 1'b0;
            if (lat_wr) begin
               store_done = 1'b1;
            end else begin
               load_done = 1'b1;
               dload     = mem[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: constant vector table, hand-written corner
// sequences, and random transactions checked against an array memory model.
module tb_cache_mem_responder;

   localparam int AB = 32;
   localparam int DW = 1024;
   localparam int L  = 2;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          dREN, dWEN, iREN;
   logic [AB-1:0] daddr, iaddr;
   logic [31:0]   dstore;
   logic          dwait, iwait, load_done, store_done, busy;
   logic [31:0]   dload, iload;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] model_mem [DW];

   typedef struct {
      bit          is_d;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [14];

   cache_mem_responder #(
      .ADDR_BITS  (AB),
      .DEPTH_WORDS(DW),
      .LATENCY    (L)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dwait     (dwait),
      .dload     (dload),
      .load_done (load_done),
      .store_done(store_done),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iwait     (iwait),
      .iload     (iload),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DW);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_now(input string nm, input bit b, input bit dw, input bit iw,
                          input bit ld, input bit sd, input logic [31:0] dl,
                          input logic [31:0] il);
      chk({nm, ".ctl"}, {27'b0, busy, dwait, iwait, load_done, store_done},
          {27'b0, b, dw, iw, ld, sd});
      chk({nm, ".dload"}, dload, dl);
      chk({nm, ".iload"}, iload, il);
   endtask

   // Samples mid-cycle, then advances to just after the next rising edge
   task automatic expect_outs(input string nm, input bit b, input bit dw, input bit iw,
                              input bit ld, input bit sd, input logic [31:0] dl,
                              input logic [31:0] il);
      @(negedge CLK);
      chk_now(nm, b, dw, iw, ld, sd, dl, il);
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit rd, input bit wr, input bit ir,
                        input logic [31:0] da, input logic [31:0] ds, input logic [31:0] ia);
      dREN   = rd;
      dWEN   = wr;
      iREN   = ir;
      daddr  = da;
      dstore = ds;
      iaddr  = ia;
   endtask

   task automatic run_txn(input string tag, input bit is_d, input bit wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp);
      drive(is_d && !wr, is_d && wr, !is_d, addr, data, addr);
      expect_outs({tag, ".idle"}, 0, 1, 1, 0, 0, '0, '0);
      for (int k = 1; k < L; k++) begin
         expect_outs($sformatf("%s.wait%0d", tag, k), 1, 1, 1, 0, 0, '0, '0);
      end
      expect_outs({tag, ".done"}, 1, !is_d, is_d, is_d && !wr, is_d && wr,
                  (is_d && !wr) ? exp : 32'h0, is_d ? 32'h0 : exp);
      if (is_d && wr) model_mem[widx(addr)] = data;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DW; i++) model_mem[i] = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{1, 0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{1, 1, 32'h0000_0100, 32'h0000_0011, 32'h0};
      tbl[3]  = '{1, 1, 32'h0000_0104, 32'h0000_0022, 32'h0};
      tbl[4]  = '{1, 0, 32'h0000_0100, 32'h0,         32'h0000_0011};
      tbl[5]  = '{1, 0, 32'h0000_0104, 32'h0,         32'h0000_0022};
      tbl[6]  = '{1, 1, 32'h0000_100C, 32'h0000_00A5, 32'h0};
      tbl[7]  = '{1, 0, 32'h0000_000C, 32'h0,         32'h0000_00A5};
      tbl[8]  = '{0, 0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
      tbl[9]  = '{1, 1, 32'h0000_0000, 32'hCAFE_0000, 32'h0};
      tbl[10] = '{1, 1, 32'h0000_0008, 32'h0000_0088, 32'h0};
      tbl[11] = '{0, 0, 32'h0000_0002, 32'h0,         32'hCAFE_0000};
      tbl[12] = '{1, 0, 32'h7FFF_F00B, 32'h0,         32'h0000_0088};
      tbl[13] = '{1, 0, 32'h0000_0044, 32'h0,         32'h0};

      clear_model();
      nRST = 1'b0;
      drive(0, 0, 0, '0, '0, '0);
      #3;
      chk_now("reset", 0, 1, 1, 0, 0, '0, '0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      expect_outs("post_reset", 0, 1, 1, 0, 0, '0, '0);

      // Back-to-back entries complete every L+1 cycles with no idle gap
      for (int i = 0; i < 14; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i].is_d, tbl[i].wr, tbl[i].addr,
                 tbl[i].data, tbl[i].exp);
      end

      drive(1, 0, 1, 32'h8, '0, 32'h0);
      expect_outs("both.idle", 0, 1, 1, 0, 0, '0, '0);
      for (int k = 1; k < L; k++) expect_outs("both.dwait", 1, 1, 1, 0, 0, '0, '0);
      expect_outs("both.ddone", 1, 0, 1, 1, 0, 32'h0000_0088, '0);
      dREN = 1'b0;
      expect_outs("both.iidle", 0, 1, 1, 0, 0, '0, '0);
      for (int k = 1; k < L; k++) expect_outs("both.iwait", 1, 1, 1, 0, 0, '0, '0);
      expect_outs("both.idone", 1, 1, 0, 0, 0, '0, 32'hCAFE_0000);

      drive(0, 1, 0, 32'h20, 32'h55, '0);
      expect_outs("abort.idle", 0, 1, 1, 0, 0, '0, '0);
      drive(0, 0, 0, 32'h20, 32'h55, '0);
      expect_outs("abort.drop", 1, 1, 1, 0, 0, '0, '0);
      expect_outs("abort.back", 0, 1, 1, 0, 0, '0, '0);
      run_txn("abort.rd", 1, 0, 32'h20, '0, 32'h0);

      drive(1, 1, 0, 32'h30, 32'h1234, '0);
      expect_outs("rdwr.idle", 0, 1, 1, 0, 0, '0, '0);
      for (int k = 1; k < L; k++) expect_outs("rdwr.wait", 1, 1, 1, 0, 0, '0, '0);
      expect_outs("rdwr.done", 1, 0, 1, 0, 1, '0, '0);
      run_txn("rdwr.rd", 1, 0, 32'h30, '0, 32'h1234);

      drive(0, 1, 0, 32'h60, 32'h77, '0);
      expect_outs("rst.idle", 0, 1, 1, 0, 0, '0, '0);
      #2;
      chk_now("rst.busy", 1, 1, 1, 0, 0, '0, '0);
      nRST = 1'b0;
      #1;
      chk_now("rst.async", 0, 1, 1, 0, 0, '0, '0);
      @(posedge CLK);
      #1;
      chk_now("rst.held", 0, 1, 1, 0, 0, '0, '0);
      drive(0, 0, 0, '0, '0, '0);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      clear_model();
      run_txn("rst.rd60", 1, 0, 32'h60, '0, 32'h0);
      run_txn("rst.rd40", 1, 0, 32'h40, '0, 32'h0);

      for (int n = 0; n < 80; n++) begin
         bit          is_d, wr;
         logic [31:0] addr, data;
         int          gap;
         is_d = ($urandom_range(0, 2) != 0);
         wr   = is_d && ($urandom_range(0, 1) == 1);
         addr = 32'($urandom_range(0, 3)) * 32'(DW * 4) + 32'($urandom_range(0, 15)) * 4
                + 32'($urandom_range(0, 3));
         data = $urandom;
         run_txn($sformatf("rnd%0d", n), is_d, wr, addr, data, model_mem[widx(addr)]);
         gap = int'($urandom_range(0, 2));
         if (gap > 0) drive(0, 0, 0, '0, '0, '0);
         for (int g = 0; g < gap; g++) begin
            expect_outs($sformatf("rnd%0d.gap", n), 0, 1, 1, 0, 0, '0, '0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
Memory-side responder for the cache request interface. It services data-cache word reads and writes (dREN/dWEN, daddr, dstore) and instruction-cache reads (iREN, iaddr) against an internal word-addressed RAM with fixed access latency. It drives the wait, load-data and load_done/store_done completion strobes that the caches use to advance their fill, writeback and flush state machines.

Parameters:
ADDR_BITS, 32, byte address width.
DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two.
LATENCY, 2, cycles from request acceptance to completion; must be >= 1.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_BITS  dcache byte address
dstore  in  32  dcache write data
dwait  out  1  dcache wait; low only in the completion cycle
dload  out  32  dcache read data, valid when dwait low on a read
load_done  out  1  one-cycle strobe: dcache read completes
store_done  out  1  one-cycle strobe: dcache write completes
iREN  in  1  icache read request
iaddr  in  ADDR_BITS  icache byte address
iwait  out  1  icache wait; low only in the completion cycle
iload  out  32  icache read data, valid when iwait low
busy  out  1  high while a transaction is in flight (ACCESS)

Behaviour:
- One clock (CLK); reset nRST asynchronous, active-low.
- Reset: state IDLE, counter 0, latched addr/data/op/source 0, all RAM words 0. Outputs: dwait=1, iwait=1, dload=0, iload=0, load_done=0, store_done=0, busy=0.
- Word index = addr[BYTE+log2(DEPTH_WORDS)-1 : 2]; addr[1:0] ignored; upper bits ignored (wraps modulo DEPTH_WORDS).
- FSM states: IDLE, ACCESS.
- IDLE: priority dWEN > dREN > iREN. If any request is present, latch op (write/read), source (d/i), address, and dstore; counter <= 0; go to ACCESS. dREN and dWEN asserted together is treated as a write. With no request, stay in IDLE. Outputs in IDLE are wait=1, strobes=0.
- ACCESS: busy=1. Each cycle, compare the live request with the latched one: same source request still asserted, same op, same address.
  - On mismatch, abort: go to IDLE with no RAM write and no strobe.
  - On match with counter < LATENCY-1: counter +1, and the requester's wait stays 1.
  - On match with counter == LATENCY-1 (the completion cycle):
    - dcache read: dwait=0, dload=RAM[idx], load_done=1.
    - dcache write: dwait=0, store_done=1; RAM[idx] <= latched dstore at the clock edge.
    - icache read: iwait=0, iload=RAM[idx].
    - Then go to IDLE.
- Completion timing: a request first seen in IDLE at cycle t completes combinationally in cycle t+LATENCY. The next request can be accepted at t+LATENCY+1.
- Back-to-back requests: the dcache's two-word bursts (word0, then word1 at +4) are separate transactions, each costing LATENCY+1 cycles.
- The non-selected requester always sees wait=1, and its inputs are ignored until the next IDLE arbitration.
- A dcache request arriving while an icache access is in flight waits; there is no pre-emption.
- load_done and store_done are high only in the completion cycle and are never asserted for icache transactions.
- dload and iload are 0 outside their completion cycles.
- A read issued right after a write to the same word returns the new data.
- Asynchronous reset mid-ACCESS: return to IDLE immediately. A write not yet at its completion edge is not committed, and RAM is re-zeroed.

Test Plan:
- Reset, then dWEN=1, daddr=0x40, dstore=0xDEADBEEF held: dwait=1 for 2 cycles, then dwait=0 and store_done=1 for exactly 1 cycle. A following dREN at 0x40 returns dload=0xDEADBEEF with load_done=1 at t+2.
- Two-word fill: dREN at 0x100, then at 0x104 (preloaded 0x11, 0x22): completions at t+2 and t+5, with dload 0x11 then 0x22.
- Simultaneous iREN (0x0) and dREN (0x8) in IDLE: dcache completes first, with iwait=1 throughout. The icache completes LATENCY+1 cycles later with iload=RAM[0].
- Abort: dWEN at 0x20 with 0x55, dropped after 1 cycle: no store_done, and a later read of 0x20 returns 0.
- Wrap: write 0xA5 at address 4*DEPTH_WORDS+0xC (=0x100C at default); read at 0xC returns 0xA5. dREN+dWEN together is performed as a write.
- nRST low during ACCESS of a write: outputs return to reset values at once, store_done never pulses, and the RAM word reads 0 afterwards.
